// File: rtl/aes_enc_top.sv
`default_nettype none
// ============================================================================
// aes_enc_top : iterative AES-128 encryption core, one cipher round per clock
// Revision    : 1.0
// ============================================================================

module aes_enc_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    // Entry for input value 0 sits in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_byte = SBOX_TABLE[{8'd255 - in_byte, 3'b000} +: 8];
endmodule

module aes_enc_mixcol (
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] x0, x1, x2, x3;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    assign {a0, a1, a2, a3} = col_in;
    assign x0 = xtime(a0);
    assign x1 = xtime(a1);
    assign x2 = xtime(a2);
    assign x3 = xtime(a3);

    assign col_out = {x0 ^ x1 ^ a1 ^ a2 ^ a3,
                      a0 ^ x1 ^ x2 ^ a2 ^ a3,
                      a0 ^ a1 ^ x2 ^ x3 ^ a3,
                      x0 ^ a0 ^ a1 ^ a2 ^ x3};
endmodule

module aes_enc_key_expand (
    input  logic [127:0] key_in,
    input  logic [7:0]   rcon,
    output logic [127:0] key_out
);
    logic [31:0] rot_word;
    logic [31:0] sub_word;
    logic [31:0] w0, w1, w2, w3;

    assign rot_word = {key_in[23:0], key_in[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sub_word
        aes_enc_sbox u_sbox (
            .in_byte  (rot_word[31-8*i -: 8]),
            .out_byte (sub_word[31-8*i -: 8])
        );
    end

    assign w0 = key_in[127:96] ^ sub_word ^ {rcon, 24'h000000};
    assign w1 = key_in[95:64]  ^ w0;
    assign w2 = key_in[63:32]  ^ w1;
    assign w3 = key_in[31:0]   ^ w2;

    assign key_out = {w0, w1, w2, w3};
endmodule

module aes_enc_top (
    input  logic         clk,
    input  logic         nreset,
    input  logic         data_v_i,
    output logic         ready_o,
    input  logic [127:0] data_i,
    input  logic [127:0] key_i,
    output logic [127:0] res_o,
    output logic         res_v_o
);
    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        ROUND1  = 4'd1,
        ROUND2  = 4'd2,
        ROUND3  = 4'd3,
        ROUND4  = 4'd4,
        ROUND5  = 4'd5,
        ROUND6  = 4'd6,
        ROUND7  = 4'd7,
        ROUND8  = 4'd8,
        ROUND9  = 4'd9,
        ROUND10 = 4'd10,
        DONE    = 4'd11
    } fsm_t;

    fsm_t         fsm_q;
    fsm_t         fsm_d;
    logic [127:0] state_q;
    logic [127:0] key_q;
    logic [7:0]   rcon_q;

    logic         accept;
    logic         round_active;
    logic         last_round;
    logic [127:0] sub_bytes;
    logic [127:0] shift_rows;
    logic [127:0] mix_cols;
    logic [127:0] round_out;
    logic [127:0] key_src;
    logic [7:0]   rcon_src;
    logic [127:0] key_next;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    always_ff @(posedge clk) begin
        if (!nreset) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    always_comb begin
        fsm_d   = IDLE;
        ready_o = 1'b0;
        res_v_o = 1'b0;
        case (fsm_q)
            IDLE: begin
                ready_o = 1'b1;
                fsm_d   = data_v_i ? ROUND1 : IDLE;
            end
            ROUND1, ROUND2, ROUND3, ROUND4, ROUND5,
            ROUND6, ROUND7, ROUND8, ROUND9, ROUND10: begin
                fsm_d = fsm_t'(fsm_q + 4'd1);
            end
            DONE: begin
                ready_o = 1'b1;
                res_v_o = 1'b1;
                fsm_d   = data_v_i ? ROUND1 : IDLE;
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    assign accept       = data_v_i & ready_o;
    assign round_active = (fsm_q >= ROUND1) && (fsm_q <= ROUND10);
    assign last_round   = (fsm_q == ROUND10);

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_enc_sbox u_sbox (
            .in_byte  (state_q[127-8*i -: 8]),
            .out_byte (sub_bytes[127-8*i -: 8])
        );
    end

    // Row r of column c takes the byte from column (c + r) mod 4.
    for (genvar c = 0; c < 4; c++) begin : g_shift_col
        for (genvar r = 0; r < 4; r++) begin : g_shift_row
            assign shift_rows[127-8*(4*c+r) -: 8] =
                sub_bytes[127-8*(4*((c+r)%4)+r) -: 8];
        end
    end

    for (genvar c = 0; c < 4; c++) begin : g_mix
        aes_enc_mixcol u_mixcol (
            .col_in  (shift_rows[127-32*c -: 32]),
            .col_out (mix_cols[127-32*c -: 32])
        );
    end

    assign round_out = (last_round ? shift_rows : mix_cols) ^ key_q;

    // One expansion unit serves both the accept cycle and every round.
    assign key_src  = accept ? key_i : key_q;
    assign rcon_src = accept ? 8'h01 : rcon_q;

    aes_enc_key_expand u_key_expand (
        .key_in  (key_src),
        .rcon    (rcon_src),
        .key_out (key_next)
    );

    always_ff @(posedge clk) begin
        if (nreset) begin
            if (accept) begin
                state_q <= data_i ^ key_i;
                key_q   <= key_next;
                rcon_q  <= 8'h02;
            end else if (round_active) begin
                state_q <= round_out;
                key_q   <= key_next;
                rcon_q  <= xtime(rcon_q);
            end
        end
    end

    assign res_o = state_q;
endmodule
`default_nettype wire

// File: tb/tb_aes_enc_top.sv
`default_nettype none
// ============================================================================
// tb_aes_enc_top : directed bench for aes_enc_top with a FIPS-197 level model
// Revision       : 1.0
// ============================================================================
module tb_aes_enc_top;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk;
    logic         nreset;
    logic         data_v_i;
    logic         ready_o;
    logic [127:0] data_i;
    logic [127:0] key_i;
    logic [127:0] res_o;
    logic         res_v_o;

    int n_checks = 0;
    int n_err    = 0;
    int pulses   = 0;

    logic [7:0] sb [0:255];

    aes_enc_top dut (
        .clk      (clk),
        .nreset   (nreset),
        .data_v_i (data_v_i),
        .ready_o  (ready_o),
        .data_i   (data_i),
        .key_i    (key_i),
        .res_o    (res_o),
        .res_v_o  (res_v_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // FIPS-197 Cipher truncated after nr rounds (nr=0: initial AddRoundKey only).
    function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [127:0] key, input int nr);
        logic [31:0]  w [0:43];
        logic [7:0]   s [0:15];
        logic [7:0]   t [0:15];
        logic [7:0]   rc;
        logic [31:0]  tmp;
        logic [127:0] out;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ w[k/4][31-8*(k%4) -: 8];
        for (int rnd = 1; rnd <= nr; rnd++) begin
            for (int k = 0; k < 16; k++) s[k] = sb[s[k]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[4*c+r] = s[4*((c+r)%4)+r];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    if (rnd < 10)
                        s[4*c+r] = gmul(t[4*c+r], 8'h02) ^ gmul(t[4*c+(r+1)%4], 8'h03)
                                 ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
                    else
                        s[4*c+r] = t[4*c+r];
            for (int k = 0; k < 16; k++) s[k] = s[k] ^ w[4*rnd + k/4][31-8*(k%4) -: 8];
        end
        for (int k = 0; k < 16; k++) out[127-8*k -: 8] = s[k];
        return out;
    endfunction

    // Timeline model: age counts cycles since the accepting edge.
    initial begin : compare
        bit           seen_rst;
        bit           active;
        int           age;
        logic [127:0] blk_pt, blk_key;
        logic         exp_ready, exp_v;
        seen_rst = 1'b0; active = 1'b0; age = 0;
        blk_pt = '0; blk_key = '0;
        forever begin
            @(negedge clk);
            if (seen_rst) begin
                exp_ready = !active || (age == 11);
                exp_v     = active && (age == 11);
                chk("ready_o", 128'(ready_o), 128'(exp_ready));
                chk("res_v_o", 128'(res_v_o), 128'(exp_v));
                if (active) chk($sformatf("res_o_age%0d", age), res_o, aes_model(blk_pt, blk_key, age - 1));
                if (res_v_o === 1'b1) pulses++;
                if (nreset !== 1'b1) begin
                    active = 1'b0;
                end else if (data_v_i && exp_ready) begin
                    active = 1'b1; age = 1; blk_pt = data_i; blk_key = key_i;
                end else if (active) begin
                    if (age == 11) active = 1'b0;
                    else age++;
                end
            end
            if (nreset === 1'b0) seen_rst = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns one time unit after the accepting edge, i.e. in cycle T+1.
    task automatic send(input logic [127:0] pt, input logic [127:0] k);
        int n;
        data_i = pt; key_i = k; data_v_i = 1'b1; n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (ready_o === 1'b1) break;
            n++;
        end
        if (n >= 20) begin
            n_checks++; n_err++;
            $display("FAIL send_accept: actual=no_ready required=ready_within_20");
        end
        @(posedge clk);
        #1;
        data_v_i = 1'b0;
    endtask

    initial begin : stim
        logic [7:0] inv, bb;
        int         low, p0, bad;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++) if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
            bb = inv;
            sb[a] = bb ^ {bb[6:0], bb[7]} ^ {bb[5:0], bb[7:6]} ^ {bb[4:0], bb[7:5]} ^ {bb[3:0], bb[7:4]} ^ 8'h63;
        end

        nreset = 1'b0; data_v_i = 1'b0; data_i = '0; key_i = '0;
        repeat (3) tick();
        nreset = 1'b1;
        chk("reset_ready", 128'(ready_o), 128'(1'b1));
        chk("reset_valid", 128'(res_v_o), 128'(1'b0));

        // FIPS-197 C.1 with literal intermediate states
        send(C1_PT, C1_KEY);
        chk("c1_t1", res_o, 128'h00102030405060708090a0b0c0d0e0f0);
        tick();
        chk("c1_t2", res_o, 128'h89d810e8855ace682d1843d8cb128fe4);
        chk("c1_t2_valid", 128'(res_v_o), 128'(1'b0));
        repeat (9) tick();
        chk("c1_t11_valid", 128'(res_v_o), 128'(1'b1));
        chk("c1_t11_ct", res_o, C1_CT);
        tick();
        chk("c1_t12_valid", 128'(res_v_o), 128'(1'b0));

        // FIPS-197 Appendix B
        send(B_PT, B_KEY);
        repeat (10) tick();
        chk("appb_valid", 128'(res_v_o), 128'(1'b1));
        chk("appb_ct", res_o, B_CT);
        tick();

        // Back-to-back: App. B held valid, accepted in the DONE cycle
        send(C1_PT, C1_KEY);
        data_i = B_PT; key_i = B_KEY; data_v_i = 1'b1; low = 0;
        while (low < 20) begin
            @(negedge clk);
            if (ready_o === 1'b1) break;
            low++;
        end
        chk("b2b_ready_low_cycles", 128'(low), 128'(10));
        chk("b2b_c1_valid", 128'(res_v_o), 128'(1'b1));
        chk("b2b_c1_ct", res_o, C1_CT);
        @(posedge clk);
        #1;
        data_v_i = 1'b0;
        chk("b2b_load", res_o, B_PT ^ B_KEY);
        repeat (10) tick();
        chk("b2b_appb_valid", 128'(res_v_o), 128'(1'b1));
        chk("b2b_appb_ct", res_o, B_CT);
        tick();

        // Valid requests while busy are ignored
        send(C1_PT, C1_KEY);
        tick(); tick();
        data_v_i = 1'b1;
        repeat (6) begin
            data_i = {$urandom(), $urandom(), $urandom(), $urandom()};
            key_i  = {$urandom(), $urandom(), $urandom(), $urandom()};
            chk("busy_ready", 128'(ready_o), 128'(1'b0));
            tick();
        end
        data_v_i = 1'b0;
        tick(); tick();
        chk("busy_valid", 128'(res_v_o), 128'(1'b1));
        chk("busy_ct", res_o, C1_CT);
        tick();

        // Reset in the middle of a block
        send(C1_PT, C1_KEY);
        repeat (4) tick();
        nreset = 1'b0;
        tick();
        nreset = 1'b1;
        chk("rst_mid_ready", 128'(ready_o), 128'(1'b1));
        chk("rst_mid_valid", 128'(res_v_o), 128'(1'b0));
        p0 = pulses;
        repeat (6) tick();
        chk("rst_mid_no_pulse", 128'(pulses), 128'(p0));
        send(B_PT, B_KEY);
        repeat (10) tick();
        chk("rst_mid_appb_valid", 128'(res_v_o), 128'(1'b1));
        chk("rst_mid_appb_ct", res_o, B_CT);
        tick();

        // Idle stability
        bad = 0;
        repeat (100) begin
            tick();
            if (ready_o !== 1'b1 || res_v_o !== 1'b0) bad++;
        end
        chk("idle_stable", 128'(bad), 128'(0));
        chk("total_pulses", 128'(pulses), 128'(6));

        // Pin the reference model itself
        chk("model_c1_round1", aes_model(C1_PT, C1_KEY, 1), 128'h89d810e8855ace682d1843d8cb128fe4);
        chk("model_c1_ct", aes_model(C1_PT, C1_KEY, 10), C1_CT);
        chk("model_appb_ct", aes_model(B_PT, B_KEY, 10), B_CT);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
